// File: rtl/mipi_pkg.sv
// Shared types and default geometry for the MIPI line-to-AXIS packer.
package mipi_pkg;

    localparam int COL_NUM_DEF    = 1280;
    localparam int ROW_NUM_DEF    = 800;
    localparam int FIFO_DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SOF_PEND = 2'd1,
        LINE     = 2'd2,
        FLUSH    = 2'd3
    } packer_state_t;

    typedef struct packed {
        logic [63:0] tdata;
        logic        tlast;
        logic        tuser;
    } axis_word_t;

endpackage

// File: rtl/axis_word_fifo.sv
// First-word-fall-through FIFO of packed AXIS words.
module axis_word_fifo
    import mipi_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr,
    input  axis_word_t             i_wdata,
    input  logic                   i_rd,
    output axis_word_t             o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_free
);

    localparam int AW = $clog2(DEPTH);

    axis_word_t    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_rd;
    logic          w_wr;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_free  = (AW+1)'(DEPTH) - r_cnt;
    assign o_rdata = r_mem[r_rptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_rd = i_rd & ~o_empty;
    assign w_wr = i_wr & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mipi_line_axis_packer.sv
// Packs the extractor byte stream into 64-bit AXIS words with SOF/EOL flags.
module mipi_line_axis_packer
    import mipi_pkg::*;
#(
    parameter int COL_NUM    = COL_NUM_DEF,
    parameter int ROW_NUM    = ROW_NUM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  line_data,
    input  logic        line_valid,
    input  logic        frame_valid,
    output logic        dma_ready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        overflow,
    output logic        line_err,
    output logic [15:0] frame_count
);

    localparam int WPL = COL_NUM / 8;
    localparam int WCW = $clog2(WPL + 1);
    localparam int LCW = $clog2(ROW_NUM + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    packer_state_t  r_state;
    logic [63:0]    r_acc;
    logic [2:0]     r_byte_idx;
    logic [WCW-1:0] r_word_cnt;
    logic [LCW-1:0] r_line_cnt;
    logic           r_lv_d;
    logic           r_fv_d;
    logic           r_sof;
    logic           r_end_frame;
    logic           r_push_vld;
    axis_word_t     r_push_word;
    logic           r_overflow;
    logic           r_line_err;
    logic [15:0]    r_frame_cnt;
    logic           r_dma_ready;

    axis_word_t     w_head;
    logic           w_full;
    logic           w_empty;
    logic [FCW-1:0] w_free;
    logic [FCW-1:0] w_free_nxt;
    logic           w_pop;
    logic           w_wr_ok;
    logic           w_fv_rise;
    logic           w_fv_fall;
    logic           w_busy;
    logic           w_short;
    logic           w_line_full;
    logic           w_last_word;
    logic           w_rows_done;

    assign w_fv_rise   = frame_valid & ~r_fv_d;
    assign w_fv_fall   = ~frame_valid & r_fv_d;
    assign w_line_full = (r_word_cnt == WCW'(WPL));
    assign w_last_word = (r_word_cnt == WCW'(WPL - 1));
    assign w_rows_done = (r_line_cnt == LCW'(ROW_NUM - 1));
    // A line is in progress once bytes arrived and it is not yet complete.
    assign w_busy      = (r_byte_idx != 3'd0) |
                         ((r_word_cnt != '0) & ~w_line_full);
    assign w_short     = ~line_valid & ~r_lv_d & w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_byte_idx  <= '0;
            r_word_cnt  <= '0;
            r_line_cnt  <= '0;
            r_lv_d      <= 1'b0;
            r_fv_d      <= 1'b0;
            r_sof       <= 1'b0;
            r_end_frame <= 1'b0;
            r_push_vld  <= 1'b0;
            r_push_word <= '0;
            r_line_err  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_lv_d     <= line_valid;
            r_fv_d     <= frame_valid;
            r_push_vld <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_fv_rise) begin
                        r_state    <= SOF_PEND;
                        r_sof      <= 1'b1;
                        r_acc      <= '0;
                        r_byte_idx <= '0;
                        r_word_cnt <= '0;
                        r_line_cnt <= '0;
                    end
                end
                SOF_PEND, LINE: begin
                    if (w_fv_fall) begin
                        r_end_frame <= 1'b1;
                        r_state     <= w_busy ? FLUSH : IDLE;
                    end else if (w_short) begin
                        r_end_frame <= 1'b0;
                        r_state     <= FLUSH;
                    end else if (line_valid) begin
                        if (w_line_full) begin
                            r_line_err <= 1'b1;
                        end else if (r_byte_idx == 3'd7) begin
                            r_push_vld  <= 1'b1;
                            r_push_word <= '{tdata: {line_data, r_acc[55:0]},
                                             tlast: w_last_word,
                                             tuser: r_sof};
                            r_sof       <= 1'b0;
                            r_acc       <= '0;
                            r_byte_idx  <= '0;
                            r_word_cnt  <= r_word_cnt + WCW'(1);
                            r_state     <= LINE;
                            if (w_last_word) begin
                                r_line_cnt <= r_line_cnt + LCW'(1);
                                if (w_rows_done) begin
                                    r_frame_cnt <= r_frame_cnt + 16'd1;
                                    r_state     <= IDLE;
                                end
                            end
                        end else begin
                            r_acc[{r_byte_idx, 3'b000} +: 8] <= line_data;
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end else if (w_line_full) begin
                        r_word_cnt <= '0;
                    end
                end
                FLUSH: begin
                    // Unfilled bytes of r_acc are already zero.
                    r_push_vld  <= 1'b1;
                    r_push_word <= '{tdata: r_acc, tlast: 1'b1, tuser: r_sof};
                    r_sof       <= 1'b0;
                    r_acc       <= '0;
                    r_byte_idx  <= '0;
                    r_word_cnt  <= '0;
                    r_line_err  <= 1'b1;
                    r_line_cnt  <= r_line_cnt + LCW'(1);
                    if (r_end_frame || w_fv_fall) begin
                        r_state <= IDLE;
                    end else if (w_rows_done) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= LINE;
                    end
                end
            endcase
        end
    end

    axis_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (r_push_vld),
        .i_wdata (r_push_word),
        .i_rd    (m_axis_tready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    assign w_pop      = m_axis_tready & ~w_empty;
    assign w_wr_ok    = r_push_vld & (~w_full | w_pop);
    assign w_free_nxt = w_free + FCW'(w_pop) - FCW'(w_wr_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_dma_ready <= 1'b1;
        end else begin
            if (r_push_vld && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            r_dma_ready <= (w_free_nxt >= FCW'(WPL));
        end
    end

    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_empty ? 64'd0 : w_head.tdata;
    assign m_axis_tlast  = ~w_empty & w_head.tlast;
    assign m_axis_tuser  = ~w_empty & w_head.tuser;
    assign dma_ready     = r_dma_ready;
    assign overflow      = r_overflow;
    assign line_err      = r_line_err;
    assign frame_count   = r_frame_cnt;

endmodule

// File: tb/tb_mipi_line_axis_packer.sv
// Directed bench for mipi_line_axis_packer (COL_NUM=16, ROW_NUM=4, FIFO_DEPTH=4).
module tb_mipi_line_axis_packer;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        u;
    } obs_t;

    localparam logic [63:0] W0 = 64'h0706050403020100;
    localparam logic [63:0] W1 = 64'h0F0E0D0C0B0A0908;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  line_data = '0;
    logic        line_valid = 1'b0;
    logic        frame_valid = 1'b0;
    logic        dma_ready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        overflow;
    logic        line_err;
    logic [15:0] frame_count;

    int   n_pass = 0;
    int   n_tot  = 0;
    obs_t q[$];
    obs_t hold;
    logic stalled = 1'b0;

    mipi_line_axis_packer #(
        .COL_NUM    (16),
        .ROW_NUM    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_data     (line_data),
        .line_valid    (line_valid),
        .frame_valid   (frame_valid),
        .dma_ready     (dma_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .overflow      (overflow),
        .line_err      (line_err),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs,
                       input logic [65:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_q(input string tag, input int idx,
                         input logic [63:0] d, input logic l, input logic u);
        obs_t o;
        obs_t e;
        o = '0;
        if (idx < q.size()) o = q[idx];
        e = '{d: d, l: l, u: u};
        chk(tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int n, input int base, input int gap);
        for (int i = 0; i < n; i++) begin
            line_valid = 1'b1;
            line_data  = 8'(base + i);
            tick();
        end
        line_valid = 1'b0;
        line_data  = '0;
        repeat (gap) tick();
    endtask

    task automatic send_frame();
        frame_valid = 1'b1;
        tick();
        tick();
        for (int j = 0; j < 4; j++) send_line(16, 0, 3);
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_count"}, 66'(q.size()), 66'(8));
        for (int j = 0; j < 4; j++) begin
            chk_q($sformatf("%s_l%0d_w0", tag, j), 2 * j, W0, 1'b0, j == 0);
            chk_q($sformatf("%s_l%0d_w1", tag, j), 2 * j + 1, W1, 1'b1, 1'b0);
        end
    endtask

    // Handshake capture and hold-while-stalled checking.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 66'(m_axis_tvalid), 66'(1));
                chk("stall_word", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
                    hold);
            end
            if (m_axis_tvalid && m_axis_tready)
                q.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser});
            stalled = m_axis_tvalid && !m_axis_tready;
            hold    = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_tvalid", 66'(m_axis_tvalid), 66'(0));
        chk("rst_tdata", 66'(m_axis_tdata), 66'(0));
        chk("rst_tlast_tuser", 66'({m_axis_tlast, m_axis_tuser}), 66'(0));
        chk("rst_dma_ready", 66'(dma_ready), 66'(1));
        chk("rst_overflow", 66'(overflow), 66'(0));
        chk("rst_line_err", 66'(line_err), 66'(0));
        chk("rst_frame_count", 66'(frame_count), 66'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Full frame, sink always ready.
        m_axis_tready = 1'b1;
        send_frame();
        repeat (10) tick();
        chk_frame("t1");
        chk("t1_frame_count", 66'(frame_count), 66'(1));
        chk("t1_line_err", 66'(line_err), 66'(0));
        chk("t1_overflow", 66'(overflow), 66'(0));

        // Same frame, sink ready one cycle in three.
        q.delete();
        fork
            send_frame();
            for (int c = 0; c < 150; c++) begin
                m_axis_tready = (c % 3 == 0);
                tick();
            end
        join
        m_axis_tready = 1'b1;
        repeat (10) tick();
        chk_frame("t2");
        chk("t2_frame_count", 66'(frame_count), 66'(2));
        chk("t2_overflow", 66'(overflow), 66'(0));

        // Short line of 13 bytes.
        q.delete();
        repeat (3) tick();
        frame_valid = 1'b1;
        tick();
        tick();
        send_line(13, 0, 4);
        repeat (6) tick();
        chk("t3_count", 66'(q.size()), 66'(2));
        chk_q("t3_w0", 0, W0, 1'b0, 1'b1);
        chk_q("t3_w1", 1, 64'h0000_000C_0B0A_0908, 1'b1, 1'b0);
        chk("t3_line_err", 66'(line_err), 66'(1));
        frame_valid = 1'b0;
        repeat (3) tick();
        chk("t3_frame_count", 66'(frame_count), 66'(2));

        // frame_valid drops after 1.5 lines, then a new frame starts.
        q.delete();
        frame_valid = 1'b1;
        tick();
        tick();
        send_line(16, 0, 3);
        send_line(8, 0, 0);
        frame_valid = 1'b0;
        repeat (6) tick();
        chk("t5_count", 66'(q.size()), 66'(4));
        chk_q("t5_w0", 0, W0, 1'b0, 1'b1);
        chk_q("t5_w1", 1, W1, 1'b1, 1'b0);
        chk_q("t5_w2", 2, W0, 1'b0, 1'b0);
        chk_q("t5_flush", 3, 64'd0, 1'b1, 1'b0);
        chk("t5_frame_count", 66'(frame_count), 66'(2));
        frame_valid = 1'b1;
        tick();
        tick();
        send_line(16, 0, 3);
        repeat (4) tick();
        chk_q("t5_sof_w0", 4, W0, 1'b0, 1'b1);
        chk_q("t5_sof_w1", 5, W1, 1'b1, 1'b0);
        frame_valid = 1'b0;
        repeat (3) tick();
        chk("t5_frame_count_end", 66'(frame_count), 66'(2));

        // Sink stalled: fill the 4-word FIFO and overflow it.
        q.delete();
        m_axis_tready = 1'b0;
        frame_valid = 1'b1;
        tick();
        tick();
        send_line(16, 0, 3);
        chk("t4_dma_ready_2w", 66'(dma_ready), 66'(1));
        chk("t4_head_tuser", 66'(m_axis_tuser), 66'(1));
        for (int i = 0; i < 16; i++) begin
            line_valid = 1'b1;
            line_data  = 8'(8'h10 + i);
            tick();
            if (i == 10) chk("t4_dma_ready_3w", 66'(dma_ready), 66'(0));
        end
        line_valid = 1'b0;
        repeat (3) tick();
        chk("t4_overflow_full", 66'(overflow), 66'(0));
        send_line(16, 8'h20, 3);
        chk("t4_overflow_drop", 66'(overflow), 66'(1));
        m_axis_tready = 1'b1;
        repeat (8) tick();
        chk("t4_count", 66'(q.size()), 66'(4));
        chk_q("t4_w0", 0, W0, 1'b0, 1'b1);
        chk_q("t4_w1", 1, W1, 1'b1, 1'b0);
        chk_q("t4_w2", 2, 64'h1716151413121110, 1'b0, 1'b0);
        chk_q("t4_w3", 3, 64'h1F1E1D1C1B1A1918, 1'b1, 1'b0);
        frame_valid = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of a line.
        m_axis_tready = 1'b0;
        frame_valid = 1'b1;
        tick();
        tick();
        send_line(11, 0, 0);
        chk("t6_tvalid_pre", 66'(m_axis_tvalid), 66'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 66'(m_axis_tvalid), 66'(0));
        chk("t6_dma_ready", 66'(dma_ready), 66'(1));
        chk("t6_frame_count", 66'(frame_count), 66'(0));
        chk("t6_flags", 66'({overflow, line_err}), 66'(0));
        frame_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t6_tvalid_post", 66'(m_axis_tvalid), 66'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
